// File: rtl/act_lut_pkg.sv
// Shared types and index helpers for the loadable activation lookup table.
// The index mapping must stay identical to the fixed activation ROMs.
package act_lut_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int lut_depth(input int w);
    return 1 << w;
  endfunction

  // Offset-binary index: inverting the MSB adds 2**(w-1) modulo 2**w.
  function automatic logic [31:0] lut_index(input logic [31:0] x, input int w);
    return x ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/act_lut_ram.sv
// Simple dual-port table RAM: synchronous write, registered read-first read, 1-cycle read latency.
// No backpressure; the read register holds its value when re_i is low.
module act_lut_ram
  import act_lut_pkg::*;
#(
  parameter int inWidth   = 10,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [inWidth-1:0]   waddr_i,
  input  logic [dataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [inWidth-1:0]   raddr_i,
  output logic [dataWidth-1:0] rdata_o
);

  logic [dataWidth-1:0] mem_q [lut_depth(inWidth)];
  logic [dataWidth-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/act_lut_writer.sv
// Loads an activation table from a valid/ready stream and serves lookups with 2-cycle latency.
// wr_ready is high throughout a load; lookups are dropped while busy or while no valid table is held.
module act_lut_writer
  import act_lut_pkg::*;
#(
  parameter int inWidth   = 10,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [dataWidth-1:0] wr_data,
  input  logic                 wr_last,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_err,
  output logic                 table_valid,
  input  logic                 x_valid,
  input  logic [inWidth-1:0]   x,
  output logic                 out_valid,
  output logic [dataWidth-1:0] out
);

  localparam logic [inWidth-1:0] LAST_ADDR = inWidth'(lut_depth(inWidth) - 1);

  state_t               state_q;
  logic [inWidth-1:0]   addr_q;
  logic                 wr_ready_q;
  logic                 busy_q;
  logic                 load_done_q;
  logic                 load_err_q;
  logic                 table_valid_q;

  logic                 beat;
  logic                 ram_we;

  logic [inWidth-1:0]   idx_d;
  logic [inWidth-1:0]   idx_q;
  logic                 v1_q;
  logic                 out_valid_q;

  assign beat   = wr_valid && wr_ready_q;
  // A restart wins over a coincident beat, so that beat must not reach the RAM.
  assign ram_we = (state_q == LOAD) && beat && !cfg_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wr_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      table_valid_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q       <= LOAD;
            addr_q        <= '0;
            table_valid_q <= 1'b0;
            load_err_q    <= 1'b0;
            busy_q        <= 1'b1;
            wr_ready_q    <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            addr_q <= '0;
          end else if (beat) begin
            addr_q <= addr_q + inWidth'(1);
            if (addr_q == LAST_ADDR && wr_last) begin
              state_q     <= DONE;
              wr_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else if (addr_q == LAST_ADDR || wr_last) begin
              state_q    <= IDLE;
              load_err_q <= 1'b1;
              busy_q     <= 1'b0;
              wr_ready_q <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          table_valid_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign idx_d = inWidth'(lut_index(32'(x), inWidth));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      v1_q        <= x_valid && table_valid_q && !busy_q;
      out_valid_q <= v1_q;
    end
  end

  act_lut_ram #(
    .inWidth  (inWidth),
    .dataWidth(dataWidth)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (ram_we),
    .waddr_i(addr_q),
    .wdata_i(wr_data),
    .re_i   (v1_q),
    .raddr_i(idx_q),
    .rdata_o(out)
  );

  assign wr_ready    = wr_ready_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign table_valid = table_valid_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_act_lut_writer.sv
// Directed bench for act_lut_writer: ramp loads, lookups, error, restart and reset-mid-load.
module tb_act_lut_writer;

  localparam int IW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          busy;
  logic          load_done;
  logic          load_err;
  logic          table_valid;
  logic          x_valid;
  logic [IW-1:0] x;
  logic          out_valid;
  logic [DW-1:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  act_lut_writer #(.inWidth(IW), .dataWidth(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .table_valid(table_valid),
    .x_valid    (x_valid),
    .x          (x),
    .out_valid  (out_valid),
    .out        (out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses cfg_start, then streams ramp data (entry i = i) until nbeats are accepted or a cycle budget expires.
  task automatic drive_load(input int nbeats, input int last_idx, input bit gaps,
                            output int accepted, output int dones);
    int  guard;
    bit  acc;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    accepted  = 0;
    dones     = 0;
    guard     = 0;
    while (accepted < nbeats && guard < 4 * nbeats + 20) begin
      wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_data  = DW'(accepted);
      wr_last  = (accepted == last_idx);
      acc      = wr_valid && wr_ready;
      step();
      if (acc) accepted++;
      if (load_done) dones++;
      guard++;
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, wr_ready, load_done, load_err, table_valid, out_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {busy, wr_ready, load_done, load_err, table_valid, out_valid});
    end
    checks++;
    if (out !== '0) begin
      errors++;
      $display("FAIL reset_out got %h want 0000", out);
    end
    #10 rst_n = 1'b1;
    step();
    x_valid = 1'b1;
    x       = '0;
    repeat (4) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_lookup_dropped got out_valid=%b want 0", out_valid);
      end
    end
    x_valid = 1'b0;
    step();
  endtask

  task automatic test_full_load();
    int acc, d;
    drive_load(1024, 1023, 1'b1, acc, d);
    checks++;
    if (acc !== 1024) begin
      errors++;
      $display("FAIL full_load_beats got %0d want 1024", acc);
    end
    checks++;
    if (load_done !== 1'b1 || d !== 1) begin
      errors++;
      $display("FAIL full_load_done got load_done=%b pulses=%0d want 1/1", load_done, d);
    end
    step();
    checks++;
    if ({load_done, table_valid, load_err, busy} !== 4'b0100) begin
      errors++;
      $display("FAIL full_load_after got done/tv/err/busy=%b want 0100",
               {load_done, table_valid, load_err, busy});
    end
  endtask

  task automatic test_lookups();
    logic [IW-1:0] xs [4];
    logic [DW-1:0] ex [4];
    xs = '{10'h000, 10'h3FF, 10'h200, 10'h1FF};
    ex = '{16'd512, 16'd511, 16'd0, 16'd1023};
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1;
      x       = xs[i];
      step();
      x_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL lookup_lat1 x=%h got out_valid=%b want 0", xs[i], out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out !== ex[i]) begin
        errors++;
        $display("FAIL lookup x=%h got v=%b out=%0d want v=1 out=%0d", xs[i], out_valid, out, ex[i]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] xs [4];
    logic [DW-1:0] ex [4];
    xs = '{10'h3FF, 10'h000, 10'h200, 10'h1FF};
    ex = '{16'd511, 16'd512, 16'd0, 16'd1023};
    for (int k = 0; k < 5; k++) begin
      x_valid = (k < 4);
      x       = (k < 4) ? xs[k] : '0;
      step();
      if (k == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_first got out_valid=%b want 0", out_valid);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out !== ex[k-1]) begin
          errors++;
          $display("FAIL b2b_%0d got v=%b out=%0d want v=1 out=%0d", k - 1, out_valid, out, ex[k-1]);
        end
      end
    end
    x_valid = 1'b0;
    step();
  endtask

  task automatic test_early_last();
    int acc, d;
    drive_load(6, 5, 1'b0, acc, d);
    checks++;
    if (acc !== 6 || d !== 0) begin
      errors++;
      $display("FAIL early_beats got beats=%0d pulses=%0d want 6/0", acc, d);
    end
    checks++;
    if ({load_err, table_valid, busy, wr_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL early_flags got err/tv/busy/rdy=%b want 1000",
               {load_err, table_valid, busy, wr_ready});
    end
    x_valid = 1'b1;
    x       = '0;
    repeat (4) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out !== 16'd1023) begin
        errors++;
        $display("FAIL early_lookup_dropped got v=%b out=%0d want v=0 out=1023", out_valid, out);
      end
    end
    x_valid   = 1'b0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    checks++;
    if (load_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL early_clear got err=%b busy=%b want 0/1", load_err, busy);
    end
  endtask

  task automatic test_restart();
    int acc, d;
    logic [IW-1:0] xs [2];
    logic [DW-1:0] ex [2];
    xs = '{10'h000, 10'h200};
    ex = '{16'd512, 16'd0};
    drive_load(300, -1, 1'b0, acc, d);
    checks++;
    if (acc !== 300 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_partial got beats=%0d busy=%b want 300/1", acc, busy);
    end
    wr_valid = 1'b1;
    wr_data  = 16'hBEEF;
    drive_load(1024, 1023, 1'b1, acc, d);
    checks++;
    if (acc !== 1024 || d !== 1 || load_done !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL restart_load got beats=%0d pulses=%0d done=%b err=%b want 1024/1/1/0",
               acc, d, load_done, load_err);
    end
    step();
    checks++;
    if (table_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_table_valid got %b want 1", table_valid);
    end
    for (int i = 0; i < 2; i++) begin
      x_valid = 1'b1;
      x       = xs[i];
      step();
      x_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out !== ex[i]) begin
        errors++;
        $display("FAIL restart_lookup x=%h got v=%b out=%0d want v=1 out=%0d", xs[i], out_valid, out, ex[i]);
      end
    end
    step();
  endtask

  task automatic test_reset_mid_load();
    int acc, d;
    logic [IW-1:0] xs [2];
    logic [DW-1:0] ex [2];
    xs = '{10'h1FF, 10'h3FF};
    ex = '{16'd1023, 16'd511};
    drive_load(700, -1, 1'b0, acc, d);
    checks++;
    if (acc !== 700 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_partial got beats=%0d busy=%b want 700/1", acc, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, table_valid, wr_ready} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_flags got busy/tv/rdy=%b want 000", {busy, table_valid, wr_ready});
    end
    #3 rst_n = 1'b1;
    step();
    drive_load(1024, 1023, 1'b0, acc, d);
    checks++;
    if (acc !== 1024 || d !== 1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_reload got beats=%0d pulses=%0d err=%b want 1024/1/0", acc, d, load_err);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      x_valid = 1'b1;
      x       = xs[i];
      step();
      x_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out !== ex[i]) begin
        errors++;
        $display("FAIL midrst_lookup x=%h got v=%b out=%0d want v=1 out=%0d", xs[i], out_valid, out, ex[i]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    cfg_start = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_last   = 1'b0;
    x_valid   = 1'b0;
    x         = '0;
    test_reset();
    test_full_load();
    test_lookups();
    test_back_to_back();
    test_early_last();
    test_restart();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
